// File: rtl/sbd_sqrt_fp_param.sv
// Parametrised IEEE-754 square root with VAL/RDY handshakes on both sides.
// Radix-2 restoring recurrence, one root bit per cycle, round-to-nearest-even
// (or truncate), special-operand handling, denormal flush, INVALID/INEXACT flags.
module sbd_sqrt_fp_param #(
    parameter int EXP_W    = 8,
    parameter int FRAC_W   = 23,
    parameter int ROUND_EN = 1
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [EXP_W+FRAC_W:0]     D_IN,
    input  logic                      VAL_IN,
    output logic                      RDY_IN,
    output logic [EXP_W+FRAC_W:0]     D_OUT,
    output logic [1:0]                FLAGS,
    output logic                      VAL_OUT,
    input  logic                      RDY_OUT
);

    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int N  = FRAC_W + 2;          // root bits: integer, fraction, guard
    localparam int XW = 2 * N;               // radicand bits consumed by the recurrence
    localparam int RW = N + 2;               // partial remainder width
    localparam int CW = $clog2(N);
    localparam logic [EXP_W:0] BIAS = {2'b00, {(EXP_W-1){1'b1}}};

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_RND, S_OUT} state_t;

    state_t state, state_nxt;

    logic [W-1:0]     op_q;
    logic [XW-1:0]    x_q;
    logic [N-1:0]     q_q;
    logic [RW-1:0]    rem_q;
    logic [CW-1:0]    cnt_q;
    logic [EXP_W-1:0] exp_q;

    // operand classification
    logic               sgn;
    logic [EXP_W-1:0]   ex;
    logic [FRAC_W-1:0]  fr;
    logic               exp_ones, exp_zero, fr_zero;
    logic               is_nan, is_zero, is_den, special;
    logic [W-1:0]       spec_res;
    logic [1:0]         spec_flags;

    // normal-path setup
    logic [EXP_W:0]     e_unb;
    logic [EXP_W-1:0]   res_exp;
    logic [FRAC_W:0]    mant;
    logic [XW-1:0]      x_init;

    // recurrence step
    logic [RW+1:0]      cur, sub;
    logic [RW-1:0]      diff, rem_nxt;
    logic               ge;

    // rounding / packing
    logic               guard, sticky, inc;
    logic [FRAC_W:0]    frac_sum;
    logic [EXP_W-1:0]   exp_r;
    logic [W-1:0]       rnd_res;

    assign sgn      = op_q[W-1];
    assign ex       = op_q[W-2:FRAC_W];
    assign fr       = op_q[FRAC_W-1:0];
    assign exp_ones = &ex;
    assign exp_zero = ~|ex;
    assign fr_zero  = ~|fr;
    assign is_nan   = exp_ones & ~fr_zero;
    assign is_zero  = exp_zero & fr_zero;
    assign is_den   = exp_zero & ~fr_zero;
    assign special  = exp_ones | exp_zero | sgn;

    // Special-case result and flags, first matching case wins
    always_comb begin
        spec_res   = '0;
        spec_flags = '0;
        if (is_nan) begin
            spec_res   = {sgn, {EXP_W{1'b1}}, 1'b1, fr[FRAC_W-2:0]};
            spec_flags = {~fr[FRAC_W-1], 1'b0};
        end else if (is_zero) begin
            spec_res   = op_q;
        end else if (is_den) begin
            spec_res   = {sgn, {(W-1){1'b0}}};
            spec_flags = 2'b01;
        end else if (sgn) begin
            spec_res   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
            spec_flags = 2'b10;
        end else if (exp_ones) begin
            spec_res   = op_q;
        end
    end

    // floor(e/2)+bias: the low EXP_W bits of (e >>> 1) are simply e[EXP_W:1]
    assign e_unb   = {1'b0, ex} - BIAS;
    assign res_exp = e_unb[EXP_W:1] + BIAS[EXP_W-1:0];
    assign mant    = {1'b1, fr};
    assign x_init  = e_unb[0] ? {mant, {(FRAC_W+3){1'b0}}}
                              : {1'b0, mant, {(FRAC_W+2){1'b0}}};

    // true difference always fits RW bits when ge, so the subtract is done narrow
    assign cur     = {rem_q, x_q[XW-1 -: 2]};
    assign sub     = {2'b00, q_q, 2'b01};
    assign ge      = (cur >= sub);
    assign diff    = cur[RW-1:0] - sub[RW-1:0];
    assign rem_nxt = ge ? diff : cur[RW-1:0];

    assign guard    = q_q[0];
    assign sticky   = |rem_q;
    assign inc      = (ROUND_EN != 0) & guard;
    assign frac_sum = {1'b0, q_q[N-2:1]} + {{FRAC_W{1'b0}}, inc};
    assign exp_r    = exp_q + {{(EXP_W-1){1'b0}}, frac_sum[FRAC_W]};
    assign rnd_res  = {1'b0, exp_r, frac_sum[FRAC_W-1:0]};

    assign RDY_IN  = (state == S_IDLE);
    assign VAL_OUT = (state == S_OUT);

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (VAL_IN) state_nxt = S_PREP;
            S_PREP: state_nxt = special ? S_OUT : S_ITER;
            S_ITER: if (cnt_q == CW'(N-1)) state_nxt = S_RND;
            S_RND:  state_nxt = S_OUT;
            S_OUT:  if (RDY_OUT) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, recurrence and result registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_q  <= '0;
            x_q   <= '0;
            q_q   <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            exp_q <= '0;
            D_OUT <= '0;
            FLAGS <= '0;
        end else begin
            case (state)
                S_IDLE: if (VAL_IN) op_q <= D_IN;
                S_PREP: begin
                    if (special) begin
                        D_OUT <= spec_res;
                        FLAGS <= spec_flags;
                    end else begin
                        x_q   <= x_init;
                        q_q   <= '0;
                        rem_q <= '0;
                        cnt_q <= '0;
                        exp_q <= res_exp;
                    end
                end
                S_ITER: begin
                    x_q   <= {x_q[XW-3:0], 2'b00};
                    q_q   <= {q_q[N-2:0], ge};
                    rem_q <= rem_nxt;
                    cnt_q <= cnt_q + CW'(1);
                end
                S_RND: begin
                    D_OUT <= rnd_res;
                    FLAGS <= {1'b0, guard | sticky};
                end
                default: ;
            endcase
        end
    end

endmodule
